// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
//   chk_state_t : sweep FSM state encoding
//   CNT_W       : settle counter width (SETTLE range 0..15)
//   TT_*        : 2-input truth tables, bit i = expected y for stim == i
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    localparam int CNT_W = 4;

    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_truth_checker_settle_counter.sv
// settle_counter: loadable down-counter that times how long each stimulus
// vector is held before the gate output is sampled.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count == 0
//   last       : count == 1 (this cycle is the final hold cycle)
module settle_counter
    import gate_check_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input combination of a gate-under-test
// in binary order, samples its output after SETTLE idle cycles, and checks
// each sample against the EXPECT truth table.
//   clk, rst_n     : clock, async active-low reset
//   start          : one-cycle sweep request (ignored while busy)
//   stim           : vector driven to the gate (stim[1]=a, stim[0]=b for 2-in)
//   y              : gate output
//   busy           : sweep in progress
//   done           : sweep finished, sticky until next accepted start
//   pass           : done with zero mismatches
//   err_count      : number of mismatching vectors
//   first_fail     : first mismatching vector
//   first_fail_vld : first_fail is valid
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 1,
    parameter logic [2**N_IN-1:0]  EXPECT = TT_OR2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [N_IN-1:0]  LAST_VEC  = '1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam bit               NO_SETTLE = (SETTLE == 0);

    chk_state_t state_q, state_d;

    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic accept;
    logic at_last;
    logic exp_bit;
    logic mismatch;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic cnt_last;

    // start is only honoured when no sweep is running
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign at_last  = (stim_q == LAST_VEC);
    assign exp_bit  = EXPECT[stim_q];
    // Case inequality so an X/Z on y is scored as a mismatch in simulation
    assign mismatch = (y !== exp_bit);

    assign cnt_load = accept || ((state_q == ST_CHECK) && !at_last);
    assign cnt_dec  = (state_q == ST_HOLD);

    settle_counter #(
        .W (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = NO_SETTLE ? ST_CHECK : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Leaving on count==1 gives SETTLE hold cycles plus the
                // CHECK cycle, i.e. SETTLE+1 cycles per vector. zero is a
                // guard against a stuck HOLD.
                if (cnt_last || cnt_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (at_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = NO_SETTLE ? ST_CHECK : ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        stim_d = stim_q;
        err_d  = err_q;
        ff_d   = ff_q;
        ffv_d  = ffv_q;
        busy_d = busy_q;
        done_d = done_q;
        if (accept) begin
            stim_d = '0;
            err_d  = '0;
            ff_d   = '0;
            ffv_d  = 1'b0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (state_q == ST_CHECK) begin
            if (mismatch) begin
                // Cannot wrap: at most 2**N_IN mismatches in N_IN+1 bits
                err_d = err_q + (N_IN+1)'(1);
                if (!ffv_q) begin
                    ff_d  = stim_q;
                    ffv_d = 1'b1;
                end
            end
            if (at_last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                stim_d = stim_q + N_IN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            stim_q <= stim_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            ffv_q  <= ffv_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
    // Built only from registered state, so y cannot glitch it
    assign pass           = done_q && (err_q == '0);

endmodule
